// File: rtl/vec_append_pkg.sv
// Shared types and append function for the vector-append scheduler.
// Build option: VAPP_STALL_CNT_EN enables the output stall counter.
package vec_append_pkg;

  localparam int VEC_W  = 64;
  localparam int HALF_W = 32;
  localparam int KEEP_W = 24;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic {
    EMPTY,
    FULL
  } state_t;

  function automatic logic [HALF_W-1:0] bswap32(
    input logic [HALF_W-1:0] x
  );
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic vec_t vec_append(
    input vec_t a,
    input vec_t b
  );
    return {bswap32(a[VEC_W-1:HALF_W]), 8'h00, b[KEEP_W-1:0]};
  endfunction

endpackage

// File: rtl/vec_append_core.sv
// Combinational append datapath shared by all requesters.
// Build option: VAPP_STALL_CNT_EN (not used in this file).
module vec_append_core
  import vec_append_pkg::*;
(
  input  vec_t a,
  input  vec_t b,
  output vec_t data
);

  assign data = vec_append(a, b);

endmodule

// File: rtl/vec_append_sched.sv
// Round-robin scheduler feeding one append core into a 1-entry output slot.
// Build option: VAPP_STALL_CNT_EN enables the stall_cnt counter.
module vec_append_sched
  import vec_append_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*VEC_W-1:0] req_a,
  input  logic [N_REQ*VEC_W-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [VEC_W-1:0]       rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            stall_cnt
);

  state_t          state_q;
  state_t          state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] idx;
  logic            found;
  logic            can_issue;
  logic            grant;
  vec_t            a_sel;
  vec_t            b_sel;
  vec_t            core_data;
  vec_t            data_q;
  logic [ID_W-1:0] id_q;

  assign rsp_valid = (state_q == FULL);
  assign can_issue = !rsp_valid || rsp_ready;

  // Scan from rr_ptr upward, wrapping at N_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Reset masks the grant so nothing is accepted while held in reset.
  assign grant = found && can_issue && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[sel] = 1'b1;
  end

  assign a_sel = req_a[int'(sel)*VEC_W +: VEC_W];
  assign b_sel = req_b[int'(sel)*VEC_W +: VEC_W];

  vec_append_core u_core (
    .a    (a_sel),
    .b    (b_sel),
    .data (core_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (rsp_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      rr_ptr <= (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      id_q   <= '0;
    end else if (grant) begin
      data_q <= core_data;
      id_q   <= sel;
    end
  end

  assign rsp_data = data_q;
  assign rsp_id   = id_q;

`ifdef VAPP_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (rsp_valid && !rsp_ready
                 && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_vec_append_sched.sv
// Directed and randomized self-checking bench for vec_append_sched.
// Build option: VAPP_STALL_CNT_EN changes the expected stall count.
module tb_vec_append_sched;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*64-1:0] req_a;
  logic [N*64-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [63:0]     rsp_data;
  logic [IW-1:0]   rsp_id;
  logic [31:0]     stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_d [N];
  logic [63:0] q_data [$];
  logic [IW-1:0] q_id [$];
  int          waitc [N];
  int          max_wait;
  logic [31:0] exp_stall;

  vec_append_sched #(.N_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [63:0] a,
                                        input logic [63:0] b);
    return {a[39:32], a[47:40], a[55:48], a[63:56], 8'h00, b[23:0]};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        hs;
    logic [IW-1:0] g;
    logic [N-1:0] pend;

    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a = '0;
    req_b = '0;
    tick();
    tick();
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data", rsp_data, 64'd0);
    chk("rst_id", 64'(rsp_id), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    // Test 1: single request
    req_a[63:0] = 64'h1122_3344_0000_0000;
    req_b[63:0] = 64'h0000_0000_00AB_CDEF;
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    #1;
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_data", rsp_data, 64'h4433_2211_00AB_CDEF);
    chk("t1_id", 64'(rsp_id), 64'd0);
    tick();
    chk("t1_drain", 64'(rsp_valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Test 2: all valid, round robin
    exp_d[0] = 64'hD0C0_B0A0_0055_AA00;
    exp_d[1] = 64'hD1C0_B0A0_0055_AA01;
    exp_d[2] = 64'hD2C0_B0A0_0055_AA02;
    exp_d[3] = 64'hD3C0_B0A0_0055_AA03;
    for (int i = 0; i < N; i++) begin
      req_a[64*i +: 64] = {32'hA0B0_C0D0 + 32'(i), 32'hDEAD_BEEF};
      req_b[64*i +: 64] = {40'hFF_FFFF_FFFF, 24'h55AA00 + 24'(i)};
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("t2_id", 64'(rsp_id), 64'(k % 4));
      chk("t2_data", rsp_data, exp_d[k % 4]);
    end

    // Test 3: back-pressure
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_noready", 64'(req_ready), 64'd0);
      tick();
      chk("t3_hold_v", 64'(rsp_valid), 64'd1);
      chk("t3_hold_d", rsp_data, exp_d[0]);
      chk("t3_hold_id", 64'(rsp_id), 64'd0);
    end
`ifdef VAPP_STALL_CNT_EN
    exp_stall = 32'd5;
`else
    exp_stall = 32'd0;
`endif
    chk("t3_stall", 64'(stall_cnt), 64'(exp_stall));
    rsp_ready = 1'b1;
    #1;
    chk("t3_release", 64'(req_ready), 64'h2);
    tick();
    chk("t3_id", 64'(rsp_id), 64'd1);
    chk("t3_data", rsp_data, exp_d[1]);

    // Test 4: wrap from rr_ptr=2
    req_valid = 4'b0011;
    #1;
    chk("t4_wrap0", 64'(req_ready), 64'h1);
    tick();
    chk("t4_id0", 64'(rsp_id), 64'd0);
    #1;
    chk("t4_wrap1", 64'(req_ready), 64'h2);
    tick();
    chk("t4_id1", 64'(rsp_id), 64'd1);
    req_valid = '0;
    tick();
    chk("idle_empty", 64'(rsp_valid), 64'd0);
    req_valid = 4'b1111;
    #1;
    chk("ptr_hold", 64'(req_ready), 64'h4);
    tick();
    chk("ptr_hold_id", 64'(rsp_id), 64'd2);

    // Test 5: reset while full
    rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("t5_valid", 64'(rsp_valid), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd0);
    chk("t5_stall", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("t5_first", 64'(req_ready), 64'h1);
    tick();
    chk("t5_id", 64'(rsp_id), 64'd0);
    chk("t5_data", rsp_data, exp_d[0]);
    req_valid = '0;
    tick();

    // Test 6: random traffic against scoreboard
    pend = '0;
    max_wait = 0;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && c < 2980 && $urandom_range(1, 0) == 1) begin
          pend[i] = 1'b1;
          req_a[64*i +: 64] = {$urandom(), $urandom()};
          req_b[64*i +: 64] = {$urandom(), $urandom()};
        end
      end
      req_valid = pend;
      rsp_ready = (c >= 2980) ? 1'b1 : ($urandom_range(3, 0) != 0);
      #1;
      chk("r_legal", 64'(($countones(req_ready) <= 1)
          && ((req_ready & ~req_valid) == '0)
          && !(rsp_valid && !rsp_ready && req_ready != '0)), 64'd1);
      if (rsp_valid && rsp_ready) begin
        if (q_data.size() == 0) begin
          chk("r_spurious", 64'd1, 64'd0);
        end else begin
          chk("r_id", 64'(rsp_id), 64'(q_id.pop_front()));
          chk("r_data", rsp_data, q_data.pop_front());
        end
      end
      hs = (req_ready != '0);
      g = '0;
      for (int i = 0; i < N; i++)
        if (req_ready[i]) g = IW'(i);
      if (hs) begin
        q_id.push_back(g);
        q_data.push_back(model(req_a[64*g +: 64], req_b[64*g +: 64]));
        for (int i = 0; i < N; i++) begin
          if (pend[i] && IW'(i) != g) begin
            waitc[i]++;
            if (waitc[i] > max_wait) max_wait = waitc[i];
          end
        end
        waitc[g] = 0;
      end
      tick();
      if (hs) pend[g] = 1'b0;
    end
    chk("r_all_returned", 64'(q_data.size()), 64'd0);
    chk("r_starve", 64'(max_wait <= N - 1), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
